reg_file_2r1w: RTL and testbench

- 32 x 32-bit general-purpose register file for the MIPS pipeline: two read ports (rs, rt), one write port (rd).
- Sits in the decode stage; its read ports feed the ALU operand path.
- Each read port is a bank of 32 bit-wise 32-to-1 selectors (`mux_32to1` per output bit) over the register array.
- Register 0 is hardwired to zero, per MIPS convention.

---
 rtl/reg_file_2r1w_pkg.sv | 34 +++
 rtl/reg_file_2r1w_read_port.sv | 63 ++++++
 rtl/reg_file_2r1w.sv | 122 ++++++++++++
 tb/tb_reg_file_2r1w.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/reg_file_2r1w_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w_pkg
//
// Purpose:
//     Shared constants and helpers for the 2-read / 1-write MIPS register
//     file. The register file, its read ports and the bit-slice selectors
//     all size themselves from these values.
//
// Contents:
//     REG_DATA_W    - register width in bits (32)
//     REG_NUM       - number of architectural registers (32)
//     REG_ADDR_W    - register index width (5)
//     REG_ZERO_IDX  - index of the hardwired-zero register ($zero)
//     REG_RESET_VAL - value every register takes on reset
//     isZeroIdx()   - true when an index names the hardwired-zero register
// ----------------------------------------------------------------------------
package reg_file_2r1w_pkg;

    localparam int REG_DATA_W = 32;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO_IDX  = 5'd0;
    localparam logic [REG_DATA_W-1:0] REG_RESET_VAL = 32'h0000_0000;

    typedef logic [REG_DATA_W-1:0] regWord_t;
    typedef logic [REG_ADDR_W-1:0] regAddr_t;

    // Register 0 is $zero: writes to it are dropped and reads of it return 0.
    function automatic logic isZeroIdx(input regAddr_t idx);
        return (idx == REG_ZERO_IDX);
    endfunction

endpackage : reg_file_2r1w_pkg

// File: rtl/reg_file_2r1w_read_port.sv
// ----------------------------------------------------------------------------
// mux_32to1 / reg_read_port
//
// Purpose:
//     mux_32to1 is a single-bit 32-to-1 selector. reg_read_port builds one
//     asynchronous read port of the register file from 32 of them: the
//     selector for output bit j looks at bit j of every register and picks
//     the one named by the read address.
//
// mux_32to1 ports:
//     d_i     [31:0]  one candidate bit per register
//     sel_i   [4:0]   register index
//     y_o             selected bit
//
// reg_read_port ports:
//     regsFlat_i [REG_NUM*REG_DATA_W-1:0]  register array, register i at
//                                          bits [i*REG_DATA_W +: REG_DATA_W]
//     addr_i     [REG_ADDR_W-1:0]          register index to read
//     data_o     [REG_DATA_W-1:0]          raw contents of the addressed
//                                          register (no zero forcing here)
// ----------------------------------------------------------------------------
module mux_32to1
    import reg_file_2r1w_pkg::*;
(
    input  logic [REG_NUM-1:0]    d_i,
    input  logic [REG_ADDR_W-1:0] sel_i,
    output logic                  y_o
);

    // Plain indexed select; an X/Z select propagates X to this bit only.
    assign y_o = d_i[sel_i];

endmodule : mux_32to1


module reg_read_port
    import reg_file_2r1w_pkg::*;
(
    input  logic [REG_NUM*REG_DATA_W-1:0] regsFlat_i,
    input  logic [REG_ADDR_W-1:0]         addr_i,
    output logic [REG_DATA_W-1:0]         data_o
);

    // One selector per output bit. Each selector's inputs are a "column"
    // of the register array: bit j of register 0, bit j of register 1, ...
    for (genvar j = 0; j < REG_DATA_W; j++) begin : gBit
        logic [REG_NUM-1:0] column;

        always_comb begin
            column = '0;
            for (int i = 0; i < REG_NUM; i++) begin
                column[i] = regsFlat_i[i*REG_DATA_W + j];
            end
        end

        mux_32to1 uMux (
            .d_i   (column),
            .sel_i (addr_i),
            .y_o   (data_o[j])
        );
    end

endmodule : reg_read_port

// File: rtl/reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// reg_file_2r1w
//
// Purpose:
//     32 x 32-bit MIPS general-purpose register file in the decode stage.
//     Two asynchronous read ports (rs -> A, rt -> B) feed the ALU operand
//     path; one synchronous write port (rd). Register 0 is hardwired to 0.
//
// Ports:
//     clk      in   pipeline clock, state updates on rising edge
//     reset    in   synchronous active-high reset, clears all registers and
//                   takes priority over a write in the same cycle
//     we       in   write enable
//     waddr    in   [4:0]  write register index (0 = dropped)
//     wdata    in   [31:0] write data
//     raddr_a  in   [4:0]  read port A index (rs)
//     raddr_b  in   [4:0]  read port B index (rt)
//     rdata_a  out  [31:0] read port A data, combinational
//     rdata_b  out  [31:0] read port B data, combinational
//
// Configuration:
//     REG_FILE_WRITE_BYPASS_EN - when defined, a read whose address matches
//     an active non-zero write sees wdata in the same cycle (each port
//     independently; suppressed while reset is high). When undefined, a
//     colliding read returns the pre-write value until the edge.
// ----------------------------------------------------------------------------
module reg_file_2r1w
    import reg_file_2r1w_pkg::*;
#(
    parameter int DATA_W   = REG_DATA_W,
    parameter int NUM_REGS = REG_NUM,
    parameter int ADDR_W   = REG_ADDR_W
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);

    logic [DATA_W-1:0]          regFile_q [NUM_REGS];
    logic [DATA_W-1:0]          regFile_d [NUM_REGS];
    logic [NUM_REGS*DATA_W-1:0] regsFlat;
    logic [DATA_W-1:0]          rawA;
    logic [DATA_W-1:0]          rawB;

    // Next-state for the array: only the addressed register changes, and
    // $zero is pinned to the reset value so it can never hold garbage.
    always_comb begin
        regFile_d = regFile_q;
        if (we && !isZeroIdx(waddr)) begin
            regFile_d[waddr] = wdata;
        end
        regFile_d[REG_ZERO_IDX] = REG_RESET_VAL;
    end

    // Register array. Reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regFile_q[i] <= REG_RESET_VAL;
            end
        end else begin
            regFile_q <= regFile_d;
        end
    end

    // The read ports take the array as one flat vector.
    always_comb begin
        regsFlat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regsFlat[i*DATA_W +: DATA_W] = regFile_q[i];
        end
    end

    reg_read_port uPortA (
        .regsFlat_i (regsFlat),
        .addr_i     (raddr_a),
        .data_o     (rawA)
    );

    reg_read_port uPortB (
        .regsFlat_i (regsFlat),
        .addr_i     (raddr_b),
        .data_o     (rawB)
    );

    // Output stage: address 0 is forced to zero regardless of array contents;
    // with forwarding enabled a matching in-flight write overrides the array.
    // A write to $zero can never forward because the bypass requires waddr!=0.
`ifdef REG_FILE_WRITE_BYPASS_EN
    logic bypassA;
    logic bypassB;

    always_comb begin
        bypassA = we && !reset && !isZeroIdx(waddr) && (waddr == raddr_a);
        bypassB = we && !reset && !isZeroIdx(waddr) && (waddr == raddr_b);
    end

    always_comb begin
        rdata_a = isZeroIdx(raddr_a) ? REG_RESET_VAL : rawA;
        rdata_b = isZeroIdx(raddr_b) ? REG_RESET_VAL : rawB;
        if (bypassA) begin
            rdata_a = wdata;
        end
        if (bypassB) begin
            rdata_b = wdata;
        end
    end
`else
    always_comb begin
        rdata_a = isZeroIdx(raddr_a) ? REG_RESET_VAL : rawA;
        rdata_b = isZeroIdx(raddr_b) ? REG_RESET_VAL : rawB;
    end
`endif

endmodule : reg_file_2r1w

// File: tb/tb_reg_file_2r1w.sv
// ----------------------------------------------------------------------------
// tb_reg_file_2r1w
//
// Purpose:
//     Directed bench for reg_file_2r1w. Each stimulus cycle that expects a
//     read result pushes the expected rdata_a/rdata_b into a scoreboard
//     queue; a separate monitor on the falling edge pops and compares.
//     Expectations follow REG_FILE_WRITE_BYPASS_EN when it is defined.
// ----------------------------------------------------------------------------
module tb_reg_file_2r1w;

    typedef struct {
        logic [31:0] expA;
        logic [31:0] expB;
        string       tag;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr_a;
    logic [4:0]  raddr_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;

    expect_t sbQ[$];
    int      checkCount = 0;
    int      passCount  = 0;

`ifdef REG_FILE_WRITE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    reg_file_2r1w dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b)
    );

    // Free-running clock, first rising edge at 5.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One comparison; counts toward the summary line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge; the next rising
    // edge commits any write. When chk is set, queue the expected reads for
    // the monitor to compare later in this same cycle.
    task automatic applyStimulus(input logic rst, input logic wen,
                                 input logic [4:0] wa, input logic [31:0] wd,
                                 input logic [4:0] ra, input logic [4:0] rb,
                                 input bit chk, input logic [31:0] expA,
                                 input logic [31:0] expB, input string tag);
        expect_t e;
        @(posedge clk);
        #1;
        reset   = rst;
        we      = wen;
        waddr   = wa;
        wdata   = wd;
        raddr_a = ra;
        raddr_b = rb;
        if (chk) begin
            e.expA = expA;
            e.expB = expB;
            e.tag  = tag;
            sbQ.push_back(e);
        end
    endtask

    // Monitor: outputs are combinational, so the falling edge of each cycle
    // is when the DUT presents a settled result for the queued expectation.
    always @(negedge clk) begin
        expect_t e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput({e.tag, "/A"}, rdata_a, e.expA);
            checkOutput({e.tag, "/B"}, rdata_b, e.expB);
        end
    end

    initial begin
        logic [31:0] pat;
        logic [31:0] patB;
        int          waitCycles;

        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = '0; raddr_b = '0;

        // Power-up reset.
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, "");
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "reset_r0");

        // Reset clear: r5 <- DEADBEEF, then reset.
        applyStimulus(0, 1, 5, 32'hDEAD_BEEF, 5, 0, 1,
                      BYPASS ? 32'hDEAD_BEEF : 32'h0, 32'h0, "wr_r5");
        applyStimulus(1, 0, 0, 0, 5, 5, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "r5_before_reset");
        applyStimulus(0, 0, 0, 0, 5, 5, 1, 32'h0, 32'h0, "r5_after_reset");
        for (int i = 0; i < 32; i++) begin
            applyStimulus(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 32'h0, 32'h0,
                          $sformatf("cleared_%0d", i));
        end

        // Write/readback on consecutive cycles.
        applyStimulus(0, 1, 1, 32'h1234_5678, 1, 31, 1,
                      BYPASS ? 32'h1234_5678 : 32'h0, 32'h0, "wr_r1");
        applyStimulus(0, 1, 31, 32'hFFFF_FFFF, 1, 31, 1,
                      32'h1234_5678, BYPASS ? 32'hFFFF_FFFF : 32'h0, "wr_r31");
        applyStimulus(0, 0, 0, 0, 1, 31, 1, 32'h1234_5678, 32'hFFFF_FFFF, "rd_r1_r31");

        // Zero register: write dropped, bypass never forwards to r0.
        applyStimulus(0, 1, 0, 32'hAAAA_AAAA, 0, 0, 1, 32'h0, 32'h0, "wr_r0");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "rd_r0_after");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0, "rd_r0_later");

        // Collision on r7.
        applyStimulus(0, 1, 7, 32'h1, 7, 7, 1,
                      BYPASS ? 32'h1 : 32'h0, BYPASS ? 32'h1 : 32'h0, "wr_r7_1");
        applyStimulus(0, 1, 7, 32'h2, 7, 7, 1,
                      BYPASS ? 32'h2 : 32'h1, BYPASS ? 32'h2 : 32'h1, "collide_r7");
        applyStimulus(0, 0, 0, 0, 7, 7, 1, 32'h2, 32'h2, "r7_after");
        // Only port A collides; port B must be unaffected.
        applyStimulus(0, 1, 7, 32'h3, 7, 1, 1,
                      BYPASS ? 32'h3 : 32'h2, 32'h1234_5678, "collide_a_only");
        applyStimulus(0, 0, 0, 0, 1, 7, 1, 32'h1234_5678, 32'h3, "r7_r1_after");

        // Reset vs write on r3: write discarded, bypass suppressed.
        applyStimulus(1, 1, 3, 32'h55, 3, 1, 1, 32'h0, 32'h1234_5678, "rst_wr_r3");
        applyStimulus(0, 0, 0, 0, 3, 1, 1, 32'h0, 32'h0, "r3_after_rst");
        applyStimulus(0, 0, 0, 0, 7, 31, 1, 32'h0, 32'h0, "r7_r31_after_rst");

        // Sweep: reg[i] = i * 0x01010101.
        for (int i = 1; i < 32; i++) begin
            pat = 32'(i) * 32'h0101_0101;
            applyStimulus(0, 1, 5'(i), pat, 5'(i), 0, 1,
                          BYPASS ? pat : 32'h0, 32'h0, $sformatf("sweep_wr_%0d", i));
        end
        for (int i = 0; i < 32; i++) begin
            pat  = (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101;
            patB = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101;
            applyStimulus(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, pat, patB,
                          $sformatf("sweep_rd_%0d", i));
        end

        // Idle and let the monitor drain, bounded.
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, "");
        waitCycles = 0;
        while (sbQ.size() > 0 && waitCycles < 10) begin
            @(posedge clk);
            waitCycles++;
        end
        if (sbQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbQ.size());
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_reg_file_2r1w
